axis_rr_arbiter: RTL

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_arb_pkg.sv | 11 +
 rtl/axis_if.sv | 13 +
 rtl/rr_pick.sv | 33 +++
 rtl/axis_rr_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared FSM state type and counter width for the stream arbiter
package axis_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - stream handshake bundle (tdata/tvalid/tready) with master and slave views
interface axis_if #(
  parameter int AXI_DATA_WIDTH = 32
);

  logic [AXI_DATA_WIDTH-1:0] tdata;
  logic                      tvalid;
  logic                      tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request bit at or after a rotating pointer, modulo NUM_SRC
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   index_o
);

  // Walk offsets from the farthest down to zero so the request nearest rr_ptr is the last write.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found_o  = 1'b0;
    index_o  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      cand = int'(rr_ptr_i) + off;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        found_o = 1'b1;
        index_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-granular round-robin merge of NUM_SRC streams onto one master stream
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int NUM_SRC        = 4,
  localparam int IDX_W          = $clog2(NUM_SRC)
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  input  logic [NUM_SRC-1:0]                s_tlast,
  output logic [NUM_SRC-1:0]                s_tready,
  axis_if.m_axis                            m_axis,
  output logic                              m_tlast,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy,
  output logic [PKT_CNT_W-1:0]              pkt_count
);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
  logic [PKT_CNT_W-1:0]      pkt_count_q, pkt_count_d;

  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;
  logic [AXI_DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [AXI_DATA_WIDTH-1:0] mux_tdata;
  logic                      mux_tvalid;
  logic                      mux_tlast;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (s_tvalid),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .index_o  (pick_idx)
  );

  // Unpack the flat source bus so the granted lane can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  // Next-state and datapath mux; reset blanks the outputs at once so an abandoned packet leaks no beat.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    pkt_count_d = pkt_count_q;
    mux_tdata   = '0;
    mux_tvalid  = 1'b0;
    mux_tlast   = 1'b0;
    s_tready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!areset) begin
          mux_tdata             = src_data[grant_idx_q];
          mux_tvalid            = s_tvalid[grant_idx_q];
          mux_tlast             = s_tlast[grant_idx_q];
          s_tready[grant_idx_q] = m_axis.tready;
          if (mux_tvalid && m_axis.tready && mux_tlast) begin
            state_d     = ST_IDLE;
            pkt_count_d = pkt_count_q + 1'b1;
            if (grant_idx_q == IDX_W'(NUM_SRC - 1)) begin
              rr_ptr_d = '0;
            end else begin
              rr_ptr_d = grant_idx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, owner and packet counter registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m_axis.tdata  = mux_tdata;
  assign m_axis.tvalid = mux_tvalid;
  assign m_tlast       = mux_tlast;
  assign grant_idx     = grant_idx_q;
  assign busy          = (state_q == ST_GRANT);
  assign pkt_count     = pkt_count_q;

endmodule
